// File: rtl/mem_access_unit.sv
// Load/store access unit: decodes a controller request, runs one word-wide memory
// handshake with a timeout, and returns lane-extended load data in rdata.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  extmode1,
  input  logic [2:0]  extmode2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        is_load_q;
  logic [2:0]  ld_mode_q;
  logic [1:0]  off_q;

  logic        rd_only;
  logic        wr_only;
  logic        mode_ok;
  logic        aligned;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;

  // Request decode: size legality, alignment and store lane replication.
  always_comb begin
    rd_only = MemRead && !MemWrite;
    wr_only = MemWrite && !MemRead;
    mode_ok = 1'b0;
    aligned = 1'b0;
    st_be   = 4'b0000;
    st_data = 32'h0;
    if (rd_only) begin
      case (extmode1)
        3'b000: begin
          mode_ok = 1'b1;
          aligned = (addr[1:0] == 2'b00);
        end
        3'b001, 3'b010: begin
          mode_ok = 1'b1;
          aligned = 1'b1;
        end
        3'b011, 3'b100: begin
          mode_ok = 1'b1;
          aligned = !addr[0];
        end
        default: mode_ok = 1'b0;
      endcase
    end else if (wr_only) begin
      case (extmode2)
        3'b000: begin
          mode_ok = 1'b1;
          aligned = (addr[1:0] == 2'b00);
          st_be   = 4'b1111;
          st_data = wdata;
        end
        3'b010: begin
          mode_ok = 1'b1;
          aligned = 1'b1;
          st_be   = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        3'b100: begin
          mode_ok = 1'b1;
          aligned = !addr[0];
          st_be   = 4'b0011 << {addr[1], 1'b0};
          st_data = {2{wdata[15:0]}};
        end
        default: mode_ok = 1'b0;
      endcase
    end
  end

  // Lane select and extension of the returned word, using the latched offset and mode.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_mode_q)
      3'b000:  load_val = mem_rdata;
      3'b001:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b010:  load_val = {24'h0, lane_b};
      3'b011:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {16'h0, lane_h};
      default: load_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'h0;
      is_load_q  <= 1'b0;
      ld_mode_q  <= 3'b000;
      off_q      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'b0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            if (mode_ok && aligned) begin
              state_q    <= REQ;
              busy       <= 1'b1;
              mem_req    <= 1'b1;
              mem_we     <= wr_only;
              mem_addr   <= {addr[31:2], 2'b00};
              mem_wdata  <= st_data;
              mem_be     <= rd_only ? 4'b1111 : st_be;
              is_load_q  <= rd_only;
              ld_mode_q  <= extmode1;
              off_q      <= addr[1:0];
              wait_cnt_q <= 8'h0;
            end else begin
              // Rejected requests never touch the memory side.
              state_q <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state_q <= DONE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (is_load_q) rdata <= load_val;
          end else if (wait_cnt_q == TO_LAST) begin
            state_q <= DONE;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            if (is_load_q) rdata <= 32'h0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'h1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL expose the parameter TIMEOUT_CYC, default 16, giving the maximum cycles mem_req waits for mem_ack before abort (range 1-255).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port MemRead, input, 1 bit: load request level from the controller.
REQ-005 The block SHALL have the port MemWrite, input, 1 bit: store request level from the controller.
REQ-006 The block SHALL have the port addr, input, 32 bits: byte address, the ALU result.
REQ-007 The block SHALL have the port wdata, input, 32 bits: store data, rs2.
REQ-008 The block SHALL have the port extmode1, input, 3 bits: load mode; 000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU.
REQ-009 The block SHALL have the port extmode2, input, 3 bits: store mode; 000 SW, 010 SB, 100 SH.
REQ-010 The block SHALL have the port busy, output, 1 bit: high while an access is in flight.
REQ-011 The block SHALL have the port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have the port err, output, 1 bit: one-cycle pulse coincident with done on a failed access.
REQ-013 The block SHALL have the port rdata, output, 32 bits: extended load result, i.e. the MD register value.
REQ-014 The block SHALL have the ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32, word-aligned, bits[1:0]=00), mem_wdata (output, 32) and mem_be (output, 4): the memory request side.
REQ-015 The block SHALL have the ports mem_ack (input, 1) and mem_rdata (input, 32): the memory response side.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, REQ and DONE.
REQ-017 In IDLE with exactly one of MemRead/MemWrite high and the access aligned, the block SHALL latch addr, wdata and mode, go to REQ, and assert mem_req and busy from the next cycle.
REQ-018 Alignment SHALL be: byte accesses are any address; halfword accesses need addr[0]=0; word accesses need addr[1:0]=00.
REQ-019 A misaligned request, MemRead and MemWrite both high, or an undefined mode code SHALL cause IDLE->DONE with no mem_req, and err=1 and done=1 in the DONE cycle.
REQ-020 mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be registered and held stable throughout REQ until the cycle mem_ack is sampled high.
REQ-021 Stores SHALL replicate data across lanes: SB gives {4{wdata[7:0]}} with mem_be=0001<<addr[1:0]; SH gives {2{wdata[15:0]}} with mem_be=0011<<{addr[1],1'b0}; SW gives wdata with mem_be=1111.
REQ-022 Loads SHALL drive mem_we=0 and mem_be=1111.
REQ-023 When mem_ack is sampled high in REQ, the block SHALL go REQ->DONE and deassert mem_req in the same edge.
REQ-024 On that edge, for loads, rdata SHALL load the lane selected by addr[1:0]/addr[1], sign- or zero-extended per extmode1.
REQ-025 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-026 A new request seen in the DONE cycle SHALL be ignored; requests are accepted only in IDLE.
REQ-027 The REQ wait counter SHALL count cycles; when it reaches TIMEOUT_CYC without ack, the block SHALL go to DONE with err=1 and rdata forced to 0.
REQ-028 rdata SHALL hold its value between loads; stores and errored stores SHALL not change rdata.
REQ-029 Best-case latency SHALL be 3 cycles from request to done (accept, REQ with ack on the first cycle, DONE).
REQ-030 An ack arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-031 When rstn=0, the block SHALL asynchronously force the state to IDLE.
REQ-032 When rstn=0, the block SHALL asynchronously force busy, done, err, mem_req, mem_we and the wait counter to 0.
REQ-033 When rstn=0, the block SHALL asynchronously force mem_be, mem_addr, mem_wdata and rdata to 0.
REQ-034 A reset during REQ SHALL drop mem_req immediately, not at the next edge.
REQ-035 After reset release, the block SHALL accept a request on the first rising edge.

Verification
REQ-036 LB, addr=0x1003, mem_rdata=0x80FF7F01, ack after 2 cycles -> mem_addr=0x1000, rdata=0xFFFFFF80, done 1 cycle, err=0.
REQ-037 LHU, addr=0x2002, mem_rdata=0xBEEF1234 -> rdata=0x0000BEEF.
REQ-038 SB, addr=0x31, wdata=0x000000AB -> mem_we=1, mem_be=0010, mem_wdata=0xABABABAB, rdata unchanged.
REQ-039 LW, addr=0x06 -> no mem_req, done=err=1 two cycles after request.
REQ-040 With TIMEOUT_CYC=4, SW with no ack -> mem_req high 4 cycles, then done=err=1 and rdata unchanged.
REQ-041 rstn pulled low mid-REQ -> mem_req=0 asynchronously; the next LW completes normally.
